// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the two-into-one sram-like request arbiter.
// arb_state_e : arbitration FSM states (idle, grant locked to inst or data).
// TAG_*       : source tags stored in the in-order response routing FIFO.
// sram_req_t  : request fields of one sram-like master, as a single bundle.
package sram_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_LOCK_INST = 2'd1,
    ARB_LOCK_DATA = 2'd2
  } arb_state_e;

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// Bundle of every sram-like signal around the arbiter: the CPU instruction
// port, the CPU data port and the bridge-side slave port.
// modport slave  : the arbiter's view (takes requests, drives responses and m_*).
// modport master : the environment's view (CPU ports and bridge).
interface sram_req_arbiter_if;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;

  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_rdata, m_addr_ok, m_data_ok
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_rdata, m_addr_ok, m_data_ok
  );
endinterface

// File: rtl/sram_req_arbiter_tag_fifo.sv
// tag_fifo: 1-bit wide, DEPTH-entry synchronous FIFO recording which source
// owns each outstanding transaction.
// clk/reset : clock, synchronous active-high reset (drops all entries).
// push/din  : write a tag (ignored when full).
// pop       : release the head (ignored when empty).
// head      : oldest tag; empty/full: occupancy flags.
// full is cleared while popping so a push can reuse the freed slot.
module tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL) && !pop;
  assign head    = mem_q[rptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges the CPU instruction and data sram-like ports onto
// the single sram-like bridge port.
// clk/reset  : clock, synchronous active-high reset.
// bus        : all sram-like request/response signals (slave modport).
// err_orphan : sticky flag, a bridge response arrived with nothing outstanding.
// Data has priority; inst wins after losing STARVE_MAX consecutive cycles.
// A grant stays locked until its address handshake; responses are routed by
// an in-order tag FIFO.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic                clk,
  input  logic                reset,
  sram_req_arbiter_if.slave   bus,
  output logic                err_orphan
);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_e    state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          run_q;
  logic          err_orphan_q;

  logic      sel_inst, sel_data, hs;
  logic      fifo_full, fifo_empty, fifo_head;
  sram_req_t inst_f, data_f, m_f;

  assign inst_f = '{wr: bus.inst_wr, size: bus.inst_size, wstrb: bus.inst_wstrb,
                    addr: bus.inst_addr, wdata: bus.inst_wdata};
  assign data_f = '{wr: bus.data_wr, size: bus.data_size, wstrb: bus.data_wstrb,
                    addr: bus.data_addr, wdata: bus.data_wdata};

  always_comb begin
    sel_inst = 1'b0;
    sel_data = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (run_q && !fifo_full) begin
          if (bus.inst_req && (!bus.data_req || starve_q == SMAX)) sel_inst = 1'b1;
          else if (bus.data_req)                                   sel_data = 1'b1;
        end
      end
      ARB_LOCK_INST: sel_inst = 1'b1;
      ARB_LOCK_DATA: sel_data = 1'b1;
      default: ;
    endcase
  end

  // run_q holds m_req low for the first cycle after reset.
  assign bus.m_req = run_q && !fifo_full &&
                     ((sel_inst && bus.inst_req) || (sel_data && bus.data_req));
  assign m_f = sel_inst ? inst_f : (sel_data ? data_f : '0);

  assign bus.m_wr    = m_f.wr;
  assign bus.m_size  = m_f.size;
  assign bus.m_wstrb = m_f.wstrb;
  assign bus.m_addr  = m_f.addr;
  assign bus.m_wdata = m_f.wdata;

  assign hs               = bus.m_req && bus.m_addr_ok;
  assign bus.inst_addr_ok = hs && sel_inst;
  assign bus.data_addr_ok = hs && sel_data;

  assign bus.inst_data_ok = bus.m_data_ok && !fifo_empty && (fifo_head == TAG_INST);
  assign bus.data_data_ok = bus.m_data_ok && !fifo_empty && (fifo_head == TAG_DATA);
  assign bus.inst_rdata   = bus.m_rdata;
  assign bus.data_rdata   = bus.m_rdata;
  assign err_orphan       = err_orphan_q;

  always_comb begin
    starve_d = starve_q;
    if (!bus.inst_req || bus.inst_addr_ok) starve_d = '0;
    else if (starve_q != SMAX)             starve_d = starve_q + SW'(1);
  end

  tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .din   (sel_data ? TAG_DATA : TAG_INST),
    .pop   (bus.m_data_ok),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      starve_q     <= '0;
      run_q        <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      starve_q <= starve_d;
      if (bus.m_data_ok && fifo_empty) err_orphan_q <= 1'b1;
      unique case (state_q)
        ARB_IDLE: begin
          if (bus.m_req && !bus.m_addr_ok)
            state_q <= sel_data ? ARB_LOCK_DATA : ARB_LOCK_INST;
        end
        ARB_LOCK_INST, ARB_LOCK_DATA: begin
          if (hs) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;
  localparam int OUT  = 4;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic reset;
  logic err_orphan;
  always #5 clk = ~clk;

  sram_req_arbiter_if bus ();

  sram_req_arbiter #(.OUTSTANDING(OUT), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .err_orphan (err_orphan)
  );

  // Reference model: outstanding-source queue, starvation streak, locked source.
  int q[$];
  int starve;
  int lock;      // -1 none, 0 inst, 1 data
  bit run;
  bit err_m;
  int hs_log[$];
  int rsp_log[$];
  bit e_ihs, e_dhs;

  // Snapshot of DUT outputs from the latest cycle.
  logic        o_mreq, o_iaok, o_daok, o_idok, o_ddok, o_err;
  logic [31:0] o_maddr, o_irdata;

  int passed = 0, failed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_inst(input bit rq, input bit wr, input logic [1:0] sz,
                          input logic [3:0] sb, input logic [31:0] a, input logic [31:0] wd);
    bus.inst_req = rq; bus.inst_wr = wr; bus.inst_size = sz;
    bus.inst_wstrb = sb; bus.inst_addr = a; bus.inst_wdata = wd;
  endtask

  task automatic set_data(input bit rq, input bit wr, input logic [1:0] sz,
                          input logic [3:0] sb, input logic [31:0] a, input logic [31:0] wd);
    bus.data_req = rq; bus.data_wr = wr; bus.data_size = sz;
    bus.data_wstrb = sb; bus.data_addr = a; bus.data_wdata = wd;
  endtask

  task automatic idle_inputs();
    set_inst(0, 0, 0, 0, 0, 0);
    set_data(0, 0, 0, 0, 0, 0);
    bus.m_addr_ok = 0; bus.m_data_ok = 0; bus.m_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); hs_log.delete(); rsp_log.delete();
    starve = 0; lock = -1; run = 0; err_m = 0;
  endtask

  // Called at a negedge after inputs are driven; checks, then advances the model.
  task automatic cycle();
    bit full, rq, mreq, hs, dok_i, dok_d;
    int sel;
    logic        ewr;
    logic [1:0]  esz;
    logic [3:0]  esb;
    logic [31:0] ea, ewd;
    #1;
    full = (q.size() == OUT) && !bus.m_data_ok;
    sel = -1;
    if (lock >= 0) sel = lock;
    else if (run && !full) begin
      if (bus.inst_req && (!bus.data_req || starve == SMAX)) sel = 0;
      else if (bus.data_req) sel = 1;
    end
    rq   = (sel == 0) ? bus.inst_req : (sel == 1) ? bus.data_req : 1'b0;
    mreq = rq && !full && run;
    if (sel == 0) begin
      ewr = bus.inst_wr; esz = bus.inst_size; esb = bus.inst_wstrb; ea = bus.inst_addr; ewd = bus.inst_wdata;
    end else if (sel == 1) begin
      ewr = bus.data_wr; esz = bus.data_size; esb = bus.data_wstrb; ea = bus.data_addr; ewd = bus.data_wdata;
    end else begin
      ewr = 0; esz = 0; esb = 0; ea = 0; ewd = 0;
    end
    hs    = mreq && bus.m_addr_ok;
    dok_i = bus.m_data_ok && q.size() > 0 && q[0] == 0;
    dok_d = bus.m_data_ok && q.size() > 0 && q[0] == 1;

    chk("m_req",        bus.m_req,        mreq);
    chk("m_wr",         bus.m_wr,         ewr);
    chk("m_size",       bus.m_size,       esz);
    chk("m_wstrb",      bus.m_wstrb,      esb);
    chk("m_addr",       bus.m_addr,       ea);
    chk("m_wdata",      bus.m_wdata,      ewd);
    chk("inst_addr_ok", bus.inst_addr_ok, hs && sel == 0);
    chk("data_addr_ok", bus.data_addr_ok, hs && sel == 1);
    chk("inst_data_ok", bus.inst_data_ok, dok_i);
    chk("data_data_ok", bus.data_data_ok, dok_d);
    chk("inst_rdata",   bus.inst_rdata,   bus.m_rdata);
    chk("data_rdata",   bus.data_rdata,   bus.m_rdata);
    chk("err_orphan",   err_orphan,       err_m);

    o_mreq = bus.m_req; o_iaok = bus.inst_addr_ok; o_daok = bus.data_addr_ok;
    o_idok = bus.inst_data_ok; o_ddok = bus.data_data_ok; o_err = err_orphan;
    o_maddr = bus.m_addr; o_irdata = bus.inst_rdata;
    if (bus.inst_addr_ok) hs_log.push_back(0);
    if (bus.data_addr_ok) hs_log.push_back(1);
    if (bus.inst_data_ok) rsp_log.push_back(0);
    if (bus.data_data_ok) rsp_log.push_back(1);
    e_ihs = hs && sel == 0;
    e_dhs = hs && sel == 1;

    if (bus.m_data_ok) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1;
    end
    if (hs) q.push_back(sel);
    if (hs) lock = -1;
    else if (mreq) lock = sel;
    if (bus.inst_req && !e_ihs) starve = (starve < SMAX) ? starve + 1 : SMAX;
    else starve = 0;
    run = 1;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    set_inst(0, 0, 0, 0, 0, 0);
    set_data(0, 0, 0, 0, 0, 0);
    bus.m_addr_ok = 0;
    for (int i = 0; i < n; i++) begin
      bus.m_data_ok = (q.size() > 0);
      bus.m_rdata = $urandom;
      cycle();
    end
    bus.m_data_ok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pat[8];
    bit ip, dp;
    pat = '{1, 1, 1, 0, 1, 1, 1, 0};

    // Single inst read; first cycle after reset keeps m_req low.
    do_reset();
    set_inst(1, 0, 2, 4'hf, 32'hBFC00000, 0);
    bus.m_addr_ok = 1;
    cycle();
    chk("t1_first_mreq", o_mreq, 0);
    cycle();
    chk("t1_iaok", o_iaok, 1);
    chk("t1_daok", o_daok, 0);
    set_inst(0, 0, 0, 0, 0, 0);
    bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h3C1D8000;
    cycle();
    chk("t1_idok", o_idok, 1);
    chk("t1_ddok", o_ddok, 0);
    chk("t1_rdata", o_irdata, 32'h3C1D8000);
    bus.m_data_ok = 0;
    cycle();
    chk("t1_idok_clear", o_idok, 0);

    // Both requesting every cycle: D,D,D,I pattern.
    do_reset();
    cycle();
    set_inst(1, 0, 2, 4'hf, 32'hBFC00100, 0);
    set_data(1, 0, 2, 4'hf, 32'h80001000, 0);
    bus.m_addr_ok = 1;
    for (int i = 0; i < 8; i++) begin
      bus.m_data_ok = (q.size() > 0);
      bus.m_rdata = $urandom;
      cycle();
    end
    drain(3);
    chk("t2_grant_count", hs_log.size(), 8);
    chk("t2_resp_count", rsp_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_grant", (i < hs_log.size()) ? hs_log[i] : 32'hDEAD, pat[i]);
      chk("t2_resp", (i < rsp_log.size()) ? rsp_log[i] : 32'hDEAD, pat[i]);
    end

    // Data grant locked while m_addr_ok is low; inst ignored meanwhile.
    do_reset();
    cycle();
    set_data(1, 0, 2, 4'hf, 32'h00001000, 0);
    bus.m_addr_ok = 0;
    cycle();
    chk("t3_addr0", o_maddr, 32'h00001000);
    set_inst(1, 0, 2, 4'hf, 32'hBFC00010, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t3_addr_hold", o_maddr, 32'h00001000);
      chk("t3_iaok_low", o_iaok, 0);
    end
    bus.m_addr_ok = 1;
    cycle();
    chk("t3_daok", o_daok, 1);
    chk("t3_iaok_hs", o_iaok, 0);
    set_data(0, 0, 0, 0, 0, 0);
    cycle();
    chk("t3_inst_after", o_iaok, 1);
    chk("t3_inst_addr", o_maddr, 32'hBFC00010);
    drain(3);

    // Fill the FIFO; push accepted only alongside a pop.
    do_reset();
    cycle();
    bus.m_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      set_inst(1, 0, 2, 4'hf, 32'h100 + 32'(i) * 4, 0);
      cycle();
      chk("t4_fill", o_iaok, 1);
    end
    cycle();
    chk("t4_full_mreq", o_mreq, 0);
    bus.m_data_ok = 1;
    cycle();
    chk("t4_pp_mreq", o_mreq, 1);
    chk("t4_pp_iaok", o_iaok, 1);
    chk("t4_pp_idok", o_idok, 1);
    bus.m_data_ok = 0;
    cycle();
    chk("t4_still_full", o_mreq, 0);
    drain(6);

    // Data write then inst read, back-to-back responses.
    do_reset();
    cycle();
    set_data(1, 1, 2, 4'h3, 32'h00002000, 32'hCAFEF00D);
    bus.m_addr_ok = 1;
    cycle();
    chk("t5_wr_aok", o_daok, 1);
    set_data(0, 0, 0, 0, 0, 0);
    set_inst(1, 0, 2, 4'hf, 32'hBFC00020, 0);
    cycle();
    chk("t5_rd_aok", o_iaok, 1);
    set_inst(0, 0, 0, 0, 0, 0);
    bus.m_addr_ok = 0; bus.m_data_ok = 1; bus.m_rdata = 32'h11111111;
    cycle();
    chk("t5_ddok", o_ddok, 1);
    chk("t5_idok0", o_idok, 0);
    bus.m_rdata = 32'h22222222;
    cycle();
    chk("t5_idok", o_idok, 1);
    chk("t5_ddok0", o_ddok, 0);
    chk("t5_rdata", o_irdata, 32'h22222222);
    bus.m_data_ok = 0;
    cycle();
    chk("t5_quiet_i", o_idok, 0);
    chk("t5_quiet_d", o_ddok, 0);

    // Orphan response sets a sticky flag cleared only by reset.
    do_reset();
    bus.m_data_ok = 1;
    cycle();
    chk("t6_no_idok", o_idok, 0);
    chk("t6_no_ddok", o_ddok, 0);
    chk("t6_err_before", o_err, 0);
    bus.m_data_ok = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_err_sticky", o_err, 1);
    end
    do_reset();
    cycle();
    chk("t6_err_cleared", o_err, 0);

    // Randomized traffic against the model.
    do_reset();
    ip = 0; dp = 0;
    for (int i = 0; i < 600; i++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1;
        set_inst(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom), $urandom, $urandom);
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1;
        set_data(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom), $urandom, $urandom);
      end
      bus.inst_req  = ip;
      bus.data_req  = dp;
      bus.m_addr_ok = ($urandom_range(0, 3) != 0);
      bus.m_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.m_rdata   = $urandom;
      cycle();
      if (e_ihs) ip = 0;
      if (e_dhs) dp = 0;
    end
    drain(8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
